acl_gesture: RTL
================

# acl_gesture

Converts the 8-bit signed tilt samples produced by the accelerometer SPI reader into one-cycle player-control pulses: next/previous track and volume up/down. Sits directly downstream of `get_acl_data`, consuming its `x_data`/`y_data`, and feeds the MP3 playback control logic. It provides periodic sampling, dominant-axis classification, hysteresis, a hold-time qualifier and optional auto-repeat.

## Interface
- `SAMPLE_DIV`, 100000: clock cycles between sample ticks (≥2).
- `TH_HI`, 40: entry threshold on |axis| (1..127).
- `TH_LO`, 20: release threshold on |axis|, `TH_LO` ≤ `TH_HI`.
- `HOLD_SAMPLES`, 4: consecutive qualifying samples before the first pulse (≥1).
- `REPEAT_SAMPLES`, 32: samples between auto-repeat pulses (≥1; used only with repeat compiled in).
- `clk` in 1: system clock, the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `x_data` in 8: signed two's-complement X tilt.
- `y_data` in 8: signed two's-complement Y tilt.
- `next_trk` out 1: one-cycle pulse.
- `prev_trk` out 1: one-cycle pulse.
- `vol_up` out 1: one-cycle pulse.
- `vol_dn` out 1: one-cycle pulse.
- `tilt_dir` out 3: current qualified direction: 0 none, 1 X+, 2 X−, 3 Y+, 4 Y−.

## Operation
- Tick counter counts 0..`SAMPLE_DIV`−1 and wraps. The tick fires when the count is `SAMPLE_DIV`−1. No other logic changes state between ticks.
- On a tick, `x_data`/`y_data` are captured and classified.
  - Absolute value saturates: −128 gives 127.
  - The dominant axis is the one with the larger |value|. On a tie, X wins.
  - The raw direction is the dominant axis and its sign if |dom| ≥ `TH_HI`, else none.
- Direction-to-action map: X+ → `next_trk`, X− → `prev_trk`, Y+ → `vol_up`, Y− → `vol_dn`.
- FSM states: IDLE, ARM, ACTIVE. All transitions happen on ticks only.
  - **IDLE:** if raw ≠ none, latch `cand`=raw, set `hcnt`=1 and go to ARM. If `HOLD_SAMPLES`=1, instead emit the pulse and go directly to ACTIVE.
  - **ARM:** if raw == `cand`, increment `hcnt`. When `hcnt` reaches `HOLD_SAMPLES`, emit the `cand` pulse, clear `rcnt` and go to ACTIVE. Any other raw value (including none) returns to IDLE with no pulse.
  - **ACTIVE:** stays while the `cand` axis has the same sign and |value| ≥ `TH_LO`. Dominance is ignored here. Otherwise go to IDLE.
- `tilt_dir` = `cand` while in ACTIVE, else 0.
- Hysteresis: the same gesture cannot re-fire until the axis drops below `TH_LO` and then requalifies ≥ `TH_HI` for `HOLD_SAMPLES` ticks.
- At most one pulse output is high in any cycle.

## Timing
- Reset values: all pulses 0, `tilt_dir`=0, FSM=IDLE, all counters 0.
- Reset is asynchronous, including mid-ARM and mid-ACTIVE. No pulse is emitted on or after reset.
- First tick occurs `SAMPLE_DIV` cycles after `rst_n` rises.
- Pulses are registered: high exactly one `clk` cycle, the cycle after the qualifying tick.
- `tilt_dir` updates in the cycle after a tick.
- Latency from the first qualifying sample to the pulse: (`HOLD_SAMPLES`−1)·`SAMPLE_DIV` + 1 cycles after that tick.

## Configuration
- `ACL_GESTURE_REPEAT_EN` defined:
  - In ACTIVE, `rcnt` increments each tick.
  - When `rcnt` reaches `REPEAT_SAMPLES`, re-emit the pulse and clear `rcnt`. This applies only when `cand` is Y+ or Y− (volume).
  - Track directions never repeat.
  - `rcnt` saturates and is unused for X.
- Undefined: exactly one pulse per gesture. The `rcnt` logic is absent.

## Structure
- Shared package `acl_pkg`:
  - direction encoding constants (`DIR_NONE`, `DIR_XP`, `DIR_XN`, `DIR_YP`, `DIR_YN`)
  - FSM state typedef/constants
  - `abs_sat8` function.
- One sub-module: `acl_tick_gen`, the `SAMPLE_DIV` tick counter. Reusable by other sampled blocks.

## Test plan
Bench parameters: `SAMPLE_DIV`=4, `TH_HI`=40, `TH_LO`=20, `HOLD_SAMPLES`=3, `REPEAT_SAMPLES`=5.
- x=50, y=0 held for 3 ticks → one `next_trk` pulse, 1 cycle wide, 1 cycle after 3rd tick. `tilt_dir`=1. No further pulse while held.
- x=−128, y=0 → one `prev_trk`. Then x=−25 (still ≥ `TH_LO`) → stays ACTIVE. Then x=−19 → IDLE, `tilt_dir`=0.
- x=50 for 2 ticks, then x=10 → no pulse, FSM back to IDLE. Tie case x=45, y=−45 for 3 ticks → `next_trk` (X wins).
- y=60 held 3+10 ticks:
  - with `ACL_GESTURE_REPEAT_EN`: `vol_up` at tick 3, then ticks 8 and 13.
  - without it: single pulse.
  - With x=60 and repeat on: only one `next_trk`.
- `rst_n` dropped mid-ARM (x=50, after 2 ticks), released, x stays 50 → no pulse until 3 fresh ticks after reset. All outputs 0 during reset.
- y=−39 sustained → never pulses (below `TH_HI`). y=−40 → `vol_dn` after 3 ticks.

Source files
------------

// File: rtl/acl_pkg.sv
// Shared definitions for the accelerometer gesture blocks: direction codes,
// gesture FSM states and small helpers for classifying signed tilt samples.
package acl_pkg;

  localparam logic [2:0] DIR_NONE = 3'd0;
  localparam logic [2:0] DIR_XP   = 3'd1;
  localparam logic [2:0] DIR_XN   = 3'd2;
  localparam logic [2:0] DIR_YP   = 3'd3;
  localparam logic [2:0] DIR_YN   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } acl_state_t;

  // Magnitude of a signed 8-bit sample, clamped so that -128 reads as 127
  // and the result always fits in 7 bits.
  function automatic logic [6:0] abs_sat8(input logic signed [7:0] v);
    logic [6:0] mag;
    if (v == 8'sh80) begin
      mag = 7'd127;
    end else if (v[7]) begin
      mag = 7'(-v);
    end else begin
      mag = v[6:0];
    end
    return mag;
  endfunction

  // Pulse vector ordered {vol_dn, vol_up, prev_trk, next_trk}.
  function automatic logic [3:0] dir_to_pulse(input logic [2:0] dir);
    logic [3:0] p;
    case (dir)
      DIR_XP:  p = 4'b0001;
      DIR_XN:  p = 4'b0010;
      DIR_YP:  p = 4'b0100;
      DIR_YN:  p = 4'b1000;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/acl_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// The tick is high while the count sits at DIV-1, so the first tick is
// sampled DIV clock edges after reset is released.
module acl_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/acl_gesture.sv
// Tilt-to-player-control gesture detector. Samples x/y tilt on a periodic
// tick, picks the dominant axis, qualifies it with a hold count and a
// TH_HI/TH_LO hysteresis band, and emits one-cycle track/volume pulses.
// Define ACL_GESTURE_REPEAT_EN to auto-repeat volume pulses while held.
module acl_gesture
  import acl_pkg::*;
#(
  parameter int SAMPLE_DIV     = 100000,
  parameter int TH_HI          = 40,
  parameter int TH_LO          = 20,
  parameter int HOLD_SAMPLES   = 4,
  parameter int REPEAT_SAMPLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] x_data,
  input  logic signed [7:0] y_data,
  output logic              next_trk,
  output logic              prev_trk,
  output logic              vol_up,
  output logic              vol_dn,
  output logic [2:0]        tilt_dir
);

  // Hold and repeat counters share one width wide enough for either limit.
  localparam int CNT_MAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [6:0]    TH_HI_V = 7'(TH_HI);
  localparam logic [6:0]    TH_LO_V = 7'(TH_LO);
  localparam logic [CW-1:0] HOLD_V  = CW'(HOLD_SAMPLES);

  logic          tick;
  acl_state_t    state_q, state_n;
  logic [2:0]    cand_q, cand_n;
  logic [CW-1:0] hcnt_q, hcnt_n, hcnt_inc;
  logic [3:0]    pulse_q, pulse_n;
  logic [6:0]    ax, ay, dom_abs;
  logic          x_dom;
  logic [2:0]    raw_dir;
  logic          hold_ok;
`ifdef ACL_GESTURE_REPEAT_EN
  localparam logic [CW-1:0] REP_V = CW'(REPEAT_SAMPLES);
  logic [CW-1:0] rcnt_q, rcnt_n, rcnt_inc;
`endif

  acl_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Classify the current sample: dominant axis (X on a tie) above TH_HI.
  always_comb begin
    ax      = abs_sat8(x_data);
    ay      = abs_sat8(y_data);
    x_dom   = (ax >= ay);
    dom_abs = x_dom ? ax : ay;
    raw_dir = DIR_NONE;
    if (dom_abs >= TH_HI_V) begin
      if (x_dom) begin
        raw_dir = x_data[7] ? DIR_XN : DIR_XP;
      end else begin
        raw_dir = y_data[7] ? DIR_YN : DIR_YP;
      end
    end
  end

  // While active only the latched axis matters: same sign and at least TH_LO.
  always_comb begin
    hold_ok = 1'b0;
    case (cand_q)
      DIR_XP:  hold_ok = !x_data[7] && (ax >= TH_LO_V);
      DIR_XN:  hold_ok =  x_data[7] && (ax >= TH_LO_V);
      DIR_YP:  hold_ok = !y_data[7] && (ay >= TH_LO_V);
      DIR_YN:  hold_ok =  y_data[7] && (ay >= TH_LO_V);
      default: hold_ok = 1'b0;
    endcase
  end

  // Gesture FSM next-state and pulse logic; nothing moves between ticks.
  always_comb begin
    state_n  = state_q;
    cand_n   = cand_q;
    hcnt_n   = hcnt_q;
    pulse_n  = 4'b0000;
    hcnt_inc = hcnt_q + CW'(1);
`ifdef ACL_GESTURE_REPEAT_EN
    rcnt_n   = rcnt_q;
    rcnt_inc = rcnt_q + CW'(1);
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (raw_dir != DIR_NONE) begin
            cand_n = raw_dir;
            hcnt_n = CW'(1);
            if (HOLD_SAMPLES == 1) begin
              pulse_n = dir_to_pulse(raw_dir);
              state_n = ACTIVE;
`ifdef ACL_GESTURE_REPEAT_EN
              rcnt_n  = '0;
`endif
            end else begin
              state_n = ARM;
            end
          end
        end
        ARM: begin
          if (raw_dir == cand_q) begin
            hcnt_n = hcnt_inc;
            if (hcnt_inc == HOLD_V) begin
              pulse_n = dir_to_pulse(cand_q);
              state_n = ACTIVE;
`ifdef ACL_GESTURE_REPEAT_EN
              rcnt_n  = '0;
`endif
            end
          end else begin
            state_n = IDLE;
          end
        end
        ACTIVE: begin
          if (hold_ok) begin
`ifdef ACL_GESTURE_REPEAT_EN
            if (cand_q == DIR_YP || cand_q == DIR_YN) begin
              if (rcnt_inc == REP_V) begin
                pulse_n = dir_to_pulse(cand_q);
                rcnt_n  = '0;
              end else begin
                rcnt_n  = rcnt_inc;
              end
            end else if (rcnt_q != REP_V) begin
              rcnt_n = rcnt_inc;
            end
`endif
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, candidate, counters and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= DIR_NONE;
      hcnt_q  <= '0;
      pulse_q <= 4'b0000;
`ifdef ACL_GESTURE_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      cand_q  <= cand_n;
      hcnt_q  <= hcnt_n;
      pulse_q <= pulse_n;
`ifdef ACL_GESTURE_REPEAT_EN
      rcnt_q  <= rcnt_n;
`endif
    end
  end

  assign next_trk = pulse_q[0];
  assign prev_trk = pulse_q[1];
  assign vol_up   = pulse_q[2];
  assign vol_dn   = pulse_q[3];
  assign tilt_dir = (state_q == ACTIVE) ? cand_q : DIR_NONE;

endmodule
